// File: rtl/datapath.sv
// Per-channel seizure-detection datapath: windowed energy and line-length features
// over 8 blocks of 32 samples, thresholded into a registered stimulation request.
module datapath #(
  parameter int DATA_WIDTH      = 16,
  parameter int UNIT_WIDTH      = 32,
  parameter int MID_WIDTH       = 37,
  parameter int OUTPUT_WIDTH    = 40,
  parameter int LL_MID_WIDTH    = 22,
  parameter int LL_OUTPUT_WIDTH = 25,
  parameter logic [OUTPUT_WIDTH-1:0]    E_THRESH  = 40'd1_000_000_000,
  parameter logic [LL_OUTPUT_WIDTH-1:0] LL_THRESH = 25'd200_000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [DATA_WIDTH-1:0]      din,
  output logic                       stimulation,
  output logic [OUTPUT_WIDTH-1:0]    energy_out,
  output logic [LL_OUTPUT_WIDTH-1:0] ll_out
);

  localparam int HIST_DEPTH = 8;
  localparam int PTR_WIDTH  = 3;

  // stage 0
  logic signed [DATA_WIDTH-1:0] x_q, x_d;
  logic signed [DATA_WIDTH-1:0] x_prev_q, x_prev_d;
  logic                         v1_q, v1_d;

  // stage 1
  logic [UNIT_WIDTH-1:0]        sq_q, sq_d;
  logic [DATA_WIDTH:0]          ad_q, ad_d;
  logic                         v2_q, v2_d;

  // stage 2
  logic [4:0]                   cnt_q, cnt_d;
  logic [MID_WIDTH-1:0]         e_acc_q, e_acc_d;
  logic [LL_MID_WIDTH-1:0]      ll_acc_q, ll_acc_d;
  logic [MID_WIDTH-1:0]         e_hist_q [HIST_DEPTH];
  logic [MID_WIDTH-1:0]         e_hist_d [HIST_DEPTH];
  logic [LL_MID_WIDTH-1:0]      ll_hist_q [HIST_DEPTH];
  logic [LL_MID_WIDTH-1:0]      ll_hist_d [HIST_DEPTH];
  logic [PTR_WIDTH-1:0]         wr_ptr_q, wr_ptr_d;
  logic [OUTPUT_WIDTH-1:0]      e_total_q, e_total_d;
  logic [LL_OUTPUT_WIDTH-1:0]   ll_total_q, ll_total_d;
  logic                         done_q, done_d;

  // stage 3
  logic                         stim_q, stim_d;
  logic [OUTPUT_WIDTH-1:0]      energy_out_q, energy_out_d;
  logic [LL_OUTPUT_WIDTH-1:0]   ll_out_q, ll_out_d;

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic [DATA_WIDTH:0]            diff;
  logic [MID_WIDTH-1:0]           e_block_sum;
  logic [LL_MID_WIDTH-1:0]        ll_block_sum;

  always_comb begin
    prod = x_q * x_q;
    // sign-extended subtraction keeps the full difference range in DATA_WIDTH+1 bits
    diff = {x_q[DATA_WIDTH-1], x_q} - {x_prev_q[DATA_WIDTH-1], x_prev_q};
    e_block_sum  = e_acc_q + MID_WIDTH'(sq_q);
    ll_block_sum = ll_acc_q + LL_MID_WIDTH'(ad_q);
  end

  always_comb begin
    x_d          = x_q;
    x_prev_d     = x_prev_q;
    v1_d         = v1_q;
    sq_d         = sq_q;
    ad_d         = ad_q;
    v2_d         = v2_q;
    cnt_d        = cnt_q;
    e_acc_d      = e_acc_q;
    ll_acc_d     = ll_acc_q;
    e_hist_d     = e_hist_q;
    ll_hist_d    = ll_hist_q;
    wr_ptr_d     = wr_ptr_q;
    e_total_d    = e_total_q;
    ll_total_d   = ll_total_q;
    done_d       = done_q;
    stim_d       = stim_q;
    energy_out_d = energy_out_q;
    ll_out_d     = ll_out_q;

    // the whole pipeline only advances on an accepted sample
    if (en) begin
      x_d      = din;
      x_prev_d = x_q;
      v1_d     = 1'b1;

      sq_d = UNIT_WIDTH'(prod);
      ad_d = diff[DATA_WIDTH] ? -diff : diff;
      v2_d = v1_q;

      done_d = 1'b0;
      if (v2_q) begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          e_hist_d[wr_ptr_q]  = e_block_sum;
          ll_hist_d[wr_ptr_q] = ll_block_sum;
          wr_ptr_d   = wr_ptr_q + 3'd1;
          e_total_d  = e_total_q + OUTPUT_WIDTH'(e_block_sum)
                       - OUTPUT_WIDTH'(e_hist_q[wr_ptr_q]);
          ll_total_d = ll_total_q + LL_OUTPUT_WIDTH'(ll_block_sum)
                       - LL_OUTPUT_WIDTH'(ll_hist_q[wr_ptr_q]);
          e_acc_d    = '0;
          ll_acc_d   = '0;
          done_d     = 1'b1;
        end else begin
          e_acc_d  = e_block_sum;
          ll_acc_d = ll_block_sum;
        end
      end

      if (done_q) begin
        stim_d       = (e_total_q > E_THRESH) && (ll_total_q > LL_THRESH);
        energy_out_d = e_total_q;
        ll_out_d     = ll_total_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      x_q          <= '0;
      x_prev_q     <= '0;
      v1_q         <= 1'b0;
      sq_q         <= '0;
      ad_q         <= '0;
      v2_q         <= 1'b0;
      cnt_q        <= '0;
      e_acc_q      <= '0;
      ll_acc_q     <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) begin
        e_hist_q[i]  <= '0;
        ll_hist_q[i] <= '0;
      end
      wr_ptr_q     <= '0;
      e_total_q    <= '0;
      ll_total_q   <= '0;
      done_q       <= 1'b0;
      stim_q       <= 1'b0;
      energy_out_q <= '0;
      ll_out_q     <= '0;
    end else begin
      x_q          <= x_d;
      x_prev_q     <= x_prev_d;
      v1_q         <= v1_d;
      sq_q         <= sq_d;
      ad_q         <= ad_d;
      v2_q         <= v2_d;
      cnt_q        <= cnt_d;
      e_acc_q      <= e_acc_d;
      ll_acc_q     <= ll_acc_d;
      for (int i = 0; i < HIST_DEPTH; i++) begin
        e_hist_q[i]  <= e_hist_d[i];
        ll_hist_q[i] <= ll_hist_d[i];
      end
      wr_ptr_q     <= wr_ptr_d;
      e_total_q    <= e_total_d;
      ll_total_q   <= ll_total_d;
      done_q       <= done_d;
      stim_q       <= stim_d;
      energy_out_q <= energy_out_d;
      ll_out_q     <= ll_out_d;
    end
  end

  assign stimulation = stim_q;
  assign energy_out  = energy_out_q;
  assign ll_out      = ll_out_q;

endmodule

// File: tb/tb_datapath.sv
// Bench for datapath: constant vector table, hand-written latency/stall/reset
// sequences and a randomized run, all checked against a sample-history model.
module tb_datapath;

  localparam longint E_HI  = 1_000_000_000;
  localparam longint LL_HI = 200_000;
  localparam longint E_LO  = 2_000_000;
  localparam longint LL_LO = 50;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] din;
  logic        stim_hi, stim_lo;
  logic [39:0] energy_hi, energy_lo;
  logic [24:0] ll_hi, ll_lo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  datapath dut (
    .clk(clk), .rst(rst), .en(en), .din(din),
    .stimulation(stim_hi), .energy_out(energy_hi), .ll_out(ll_hi)
  );

  datapath #(16, 32, 37, 40, 22, 25, 40'd2_000_000, 25'd50) dut_lo (
    .clk(clk), .rst(rst), .en(en), .din(din),
    .stimulation(stim_lo), .energy_out(energy_lo), .ll_out(ll_lo)
  );

  // reference model: every accepted sample since reset, window recomputed from scratch
  int     samples[$];
  int     pending = 0;
  longint staged_e, staged_ll;
  longint exp_e = 0, exp_ll = 0;
  bit     exp_s_hi = 0, exp_s_lo = 0;

  typedef struct {
    int     pattern;
    int     n_samples;
    longint exp_energy;
    longint exp_ll;
    bit     exp_stim_hi;
    bit     exp_stim_lo;
  } vec_t;

  vec_t vecs[8];

  function automatic int pat(int p, int i);
    case (p)
      0:       return 100;
      1:       return (i % 2 == 0) ? 1000 : -1000;
      2:       return (i % 2 == 0) ? 20000 : -20000;
      default: return (i % 2 == 0) ? -32768 : 32767;
    endcase
  endfunction

  function automatic void stage_block();
    int     n  = samples.size();
    int     lo = (n > 256) ? n - 256 : 0;
    longint prev, d;
    staged_e  = 0;
    staged_ll = 0;
    for (int i = lo; i < n; i++) begin
      prev = (i == 0) ? 0 : samples[i-1];
      d    = samples[i] - prev;
      if (d < 0) d = -d;
      staged_e  += longint'(samples[i]) * longint'(samples[i]);
      staged_ll += d;
    end
  endfunction

  task automatic checkValue(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic checkOutput();
    checkValue("hi_stim", longint'(stim_hi), longint'(exp_s_hi));
    checkValue("hi_energy", longint'(energy_hi), exp_e);
    checkValue("hi_ll", longint'(ll_hi), exp_ll);
    checkValue("lo_stim", longint'(stim_lo), longint'(exp_s_lo));
    checkValue("lo_energy", longint'(energy_lo), exp_e);
    checkValue("lo_ll", longint'(ll_lo), exp_ll);
  endtask

  task automatic applyStimulus(input logic r, input logic e, input int d);
    rst = r;
    en  = e;
    din = 16'(d);
    @(posedge clk);
    if (!r) begin
      samples.delete();
      pending  = 0;
      exp_e    = 0;
      exp_ll   = 0;
      exp_s_hi = 0;
      exp_s_lo = 0;
    end else if (e) begin
      if (pending > 0) begin
        pending--;
        if (pending == 0) begin
          exp_e    = staged_e;
          exp_ll   = staged_ll;
          exp_s_hi = (staged_e > E_HI) && (staged_ll > LL_HI);
          exp_s_lo = (staged_e > E_LO) && (staged_ll > LL_LO);
        end
      end
      samples.push_back(d);
      if (samples.size() % 32 == 0) begin
        stage_block();
        pending = 3;
      end
    end
    #1;
    checkOutput();
  endtask

  task automatic resetDut();
    applyStimulus(1'b0, 1'b1, 1000);
    applyStimulus(1'b0, 1'b1, 1000);
  endtask

  function automatic int rand_sample(int amp);
    if (amp >= 32767) return int'($urandom_range(65535)) - 32768;
    return int'($urandom_range(2 * amp)) - amp;
  endfunction

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int rise;
    int fed;
    int amps[4];

    vecs[0] = '{0,  32,  320000,               100,     1'b0, 1'b0};
    vecs[1] = '{0, 192, 1920000,               100,     1'b0, 1'b0};
    vecs[2] = '{0, 224, 2240000,               100,     1'b0, 1'b1};
    vecs[3] = '{0, 256, 2560000,               100,     1'b0, 1'b1};
    vecs[4] = '{1,  32, 32000000,              63000,   1'b0, 1'b1};
    vecs[5] = '{1,  64, 64000000,              127000,  1'b0, 1'b1};
    vecs[6] = '{2,  32, 64'd12_800_000_000,    1260000, 1'b1, 1'b1};
    vecs[7] = '{3,  32, 64'd34_358_689_808,    2064353, 1'b1, 1'b1};

    rst = 1'b0;
    en  = 1'b0;
    din = '0;

    $display("[TB] reset hold");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1, 1000);
      checkValue("rst_stim", longint'(stim_hi), 0);
      checkValue("rst_energy", longint'(energy_hi), 0);
      checkValue("rst_ll", longint'(ll_hi), 0);
    end

    $display("[TB] vector table");
    for (int v = 0; v < 8; v++) begin
      resetDut();
      for (int i = 0; i < vecs[v].n_samples + 3; i++)
        applyStimulus(1'b1, 1'b1, pat(vecs[v].pattern, i));
      checkValue("tbl_energy", longint'(energy_hi), vecs[v].exp_energy);
      checkValue("tbl_ll", longint'(ll_hi), vecs[v].exp_ll);
      checkValue("tbl_stim_hi", longint'(stim_hi), longint'(vecs[v].exp_stim_hi));
      checkValue("tbl_stim_lo", longint'(stim_lo), longint'(vecs[v].exp_stim_lo));
    end

    $display("[TB] stimulation rise edge");
    resetDut();
    for (int i = 0; i < 224; i++) applyStimulus(1'b1, 1'b1, 100);
    checkValue("lo_stim_at_capture", longint'(stim_lo), 0);
    rise = 0;
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(1'b1, 1'b1, 100);
      if (stim_lo && rise == 0) rise = k;
    end
    checkValue("lo_rise_edge", rise, 3);

    $display("[TB] enable stalls");
    resetDut();
    fed = 0;
    while (fed < 256) begin
      if ($urandom_range(3) == 0) applyStimulus(1'b1, 1'b0, rand_sample(32767));
      else begin
        applyStimulus(1'b1, 1'b1, 100);
        fed++;
      end
    end
    fed = 0;
    while (fed < 3) begin
      if ($urandom_range(2) == 0) applyStimulus(1'b1, 1'b0, rand_sample(32767));
      else begin
        applyStimulus(1'b1, 1'b1, 100);
        fed++;
      end
    end
    checkValue("stall_energy", longint'(energy_hi), 2560000);
    checkValue("stall_ll", longint'(ll_hi), 100);

    $display("[TB] mid-block reset");
    resetDut();
    for (int i = 0; i < 49; i++) applyStimulus(1'b1, 1'b1, 100);
    checkValue("pre_rst_energy", longint'(energy_hi), 320000);
    applyStimulus(1'b0, 1'b1, 100);
    checkValue("mid_rst_energy", longint'(energy_hi), 0);
    checkValue("mid_rst_ll", longint'(ll_hi), 0);
    for (int i = 0; i < 34; i++) applyStimulus(1'b1, 1'b1, 100);
    checkValue("fresh_not_yet", longint'(energy_hi), 0);
    applyStimulus(1'b1, 1'b1, 100);
    checkValue("fresh_energy", longint'(energy_hi), 320000);
    checkValue("fresh_ll", longint'(ll_hi), 100);

    $display("[TB] randomized run");
    amps = '{200, 2000, 20000, 32767};
    resetDut();
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < 500; i++) begin
        if ($urandom_range(399) == 0) applyStimulus(1'b0, 1'b1, rand_sample(amps[s]));
        else applyStimulus(1'b1, ($urandom_range(9) != 0), rand_sample(amps[s]));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
